cla_adder_seq: RTL and testbench
================================

# cla_adder_seq

Parametrised, sequential carry-lookahead adder that adds two WIDTH-bit operands one GROUP-bit lookahead block per clock, rippling the block carry through a carry register. It is the clocked successor to the fixed 16-bit combinational CLA adder. It adds valid/ready handshakes on input and output, so it can sit in a datapath between a producer and a consumer. The GROUP-bit lookahead block (bit generate/propagate, group carries) is reused every cycle rather than replicated WIDTH/GROUP times.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of GROUP.
- GROUP, 4, bits processed per cycle by the lookahead block; legal 1..8.
- NG (localparam), WIDTH/GROUP, number of add cycles.

- clk  input  1  rising-edge clock.
- reset_n  input  1  reset; one clock; asynchronous, active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, (a+b+carry_in) mod 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow; present only with CLA_SEQ_OVERFLOW_EN.

## Operation
- Reset values: state IDLE, group counter 0, carry reg 0, in_ready 1, out_valid 0, sum 0, carry_out 0, overflow 0.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture a, b and carry_in into working regs, clear counter, load carry reg with carry_in, and go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle, feed slice k=counter (bits k*GROUP+GROUP-1 : k*GROUP) to the lookahead block: g=a&b, p=a^b, c[i+1]=g[i]|p[i]&c[i] expanded in lookahead form.
  - Write the slice sum into the working sum reg; update carry reg with the group carry-out; increment counter.
  - When counter==NG-1, copy the working sum into sum, the final carry into carry_out (and overflow if enabled), and go to DONE.
- DONE:
  - out_valid=1.
  - If out_ready: either accept new operands (in_valid=1, go to ADD) or return to IDLE.
  - If !out_ready: hold.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready to in_ready.
- sum, carry_out and overflow are registered. They change only on the final ADD cycle and hold the last completed result at all other times, including in IDLE.
- Captured operands are immune to input changes after acceptance.
- Reset asserted mid-ADD or in DONE aborts the operation. No result is emitted, and all outputs return to reset values asynchronously.

## Timing
- Input handshake at edge T0 (in_valid & in_ready). out_valid rises after edge T0+NG, i.e. latency NG cycles; 4 cycles at defaults.
- Maximum throughput is one result per NG+1 cycles, with back-to-back acceptance in DONE.
- The output handshake completes on the edge where out_valid & out_ready. out_valid falls after that edge unless a new result completes simultaneously, which cannot happen because ADD takes at least 1 cycle.
- The critical path is one GROUP-bit lookahead plus register setup, independent of WIDTH.
- GROUP==WIDTH is legal: NG=1, so latency is 1 cycle.

## Configuration
- CLA_SEQ_OVERFLOW_EN defined:
  - The overflow port exists.
  - It registers overflow = carry into MSB ^ carry_out of MSB, computed in the last ADD cycle.
  - It holds and resets with sum.
- CLA_SEQ_OVERFLOW_EN undefined: no overflow port and no MSB carry tap logic.

## Test plan
- Defaults, a=10, b=22, carry_in=0, out_ready=1 -> out_valid 4 cycles after accept; sum=32, carry_out=0. Repeat with carry_in=1 -> sum=33.
- a=16'hFFFF, b=16'h0001, carry_in=0 -> sum=0, carry_out=1. a=16'hFFFF, b=0, carry_in=1 -> sum=0, carry_out=1 (carry crosses every group).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid, sum and carry_out stable and in_ready=0 throughout. Then out_ready=1 with in_valid=1 -> new operands accepted on the same edge, and the next result arrives 4 cycles later.
- Reset: drop reset_n during the 2nd ADD cycle of 10+22 -> immediate out_valid=0, sum=0, in_ready=1. After release, 5+6 -> sum=11 with no stale output.
- WIDTH=32, GROUP=8: a=32'h8000_0000, b=32'h8000_0000 -> latency 4, sum=0, carry_out=1. WIDTH=8, GROUP=8 -> latency 1.
- With CLA_SEQ_OVERFLOW_EN: a=16'h7FFF, b=1 -> sum=16'h8000, overflow=1, carry_out=0. a=16'h8000, b=16'hFFFF -> overflow=1, carry_out=1. 10+22 -> overflow=0.

Source files
------------

// File: rtl/cla_adder_seq.sv
// Sequential carry-lookahead adder: one GROUP-bit lookahead slice per clock.
// Optional signed overflow output enabled by defining CLA_SEQ_OVERFLOW_EN.
module cla_adder_seq #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef CLA_SEQ_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NG = WIDTH / GROUP;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] wsum_q, wsum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef CLA_SEQ_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  int               base;
  logic [GROUP-1:0] ga, gb, g, p, s;
  logic [GROUP:0]   c;
  logic             cx, tt;
  logic             last;

  // Lookahead block: every group carry is a flat sum of g/p products.
  always_comb begin
    base = int'(cnt_q) * GROUP;
    ga   = a_q[base +: GROUP];
    gb   = b_q[base +: GROUP];
    g    = ga & gb;
    p    = ga ^ gb;
    c    = '0;
    cx   = 1'b0;
    tt   = 1'b0;
    c[0] = carry_q;
    for (int i = 0; i < GROUP; i++) begin
      cx = carry_q;
      for (int j = 0; j <= i; j++) cx = cx & p[j];
      for (int j = 0; j <= i; j++) begin
        tt = g[j];
        for (int k = j + 1; k <= i; k++) tt = tt & p[k];
        cx = cx | tt;
      end
      c[i+1] = cx;
    end
    s = p ^ c[GROUP-1:0];
  end

  assign last      = (cnt_q == CW'(NG - 1));
  assign out_valid = (state_q == DONE);
  assign in_ready  = (state_q == IDLE) |
                     ((state_q == DONE) & out_ready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    wsum_d  = wsum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CLA_SEQ_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        wsum_d[base +: GROUP] = s;
        carry_d = c[GROUP];
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          sum_d   = wsum_d;
          cout_d  = c[GROUP];
`ifdef CLA_SEQ_OVERFLOW_EN
          ovf_d   = c[GROUP] ^ c[GROUP-1];
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            carry_d = carry_in;
            cnt_d   = '0;
            state_d = ADD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      wsum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wsum_q  <= wsum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CLA_SEQ_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef CLA_SEQ_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder_seq.sv
// Directed scoreboard bench for cla_adder_seq (default, 32/8 and 8/8 builds).
// Overflow checks are active when CLA_SEQ_OVERFLOW_EN is defined.
module tb_cla_adder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        carry_in, carry_out;
`ifdef CLA_SEQ_OVERFLOW_EN
  logic        overflow, ov32, ov8;
`endif

  logic        v32, r32, o32, c32, ci32;
  logic [31:0] a32, b32, s32;
  logic        v8, r8, o8, c8, ci8;
  logic [7:0]  a8, b8, s8;
  logic        ordy_x;

  cla_adder_seq dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out)
`ifdef CLA_SEQ_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  cla_adder_seq #(.WIDTH(32), .GROUP(8)) u32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v32), .in_ready(r32),
    .a(a32), .b(b32), .carry_in(ci32),
    .out_valid(o32), .out_ready(ordy_x),
    .sum(s32), .carry_out(c32)
`ifdef CLA_SEQ_OVERFLOW_EN
    , .overflow(ov32)
`endif
  );

  cla_adder_seq #(.WIDTH(8), .GROUP(8)) u8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v8), .in_ready(r8),
    .a(a8), .b(b8), .carry_in(ci8),
    .out_valid(o8), .out_ready(ordy_x),
    .sum(s8), .carry_out(c8)
`ifdef CLA_SEQ_OVERFLOW_EN
    , .overflow(ov8)
`endif
  );

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sbq[$];
  exp_t e_last;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                      input logic tci, input bit push);
    int   w;
    logic [16:0] full;
    exp_t e;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk("in_ready_at_accept", in_ready, 1);
    a        = ta;
    b        = tb;
    carry_in = tci;
    in_valid = 1'b1;
    if (push) begin
      full = {1'b0, ta} + {1'b0, tb} + {16'd0, tci};
      e.s  = full[15:0];
      e.co = full[16];
      e.ov = (ta[15] == tb[15]) && (full[15] != ta[15]);
      sbq.push_back(e);
    end
    step();
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    carry_in = 1'b1;
  endtask

  task automatic collect(input string tag, input int lat);
    int w;
    w = 0;
    while (!out_valid && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_latency"}, w, lat);
    chk({tag, "_sb_nonempty"}, sbq.size() != 0, 1);
    if (sbq.size() != 0) begin
      e_last = sbq.pop_front();
      chk({tag, "_sum"}, sum, e_last.s);
      chk({tag, "_cout"}, carry_out, e_last.co);
`ifdef CLA_SEQ_OVERFLOW_EN
      chk({tag, "_ovf"}, overflow, e_last.ov);
`endif
    end
  endtask

  initial begin
    int w;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ordy_x    = 1'b1;
    a = '0; b = '0; carry_in = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", carry_out, 0);
    step();
    reset_n = 1'b1;
    step();

    send(16'd10, 16'd22, 1'b0, 1'b1);
    collect("add_10_22", 4);
    step();
    chk("idle_after_hs", out_valid, 0);
    chk("hold_in_idle", sum, 16'd32);

    send(16'd10, 16'd22, 1'b1, 1'b1);
    collect("add_10_22_ci", 4);
    step();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    collect("ffff_p1", 4);
    step();
    send(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    collect("ffff_ci", 4);
    step();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    collect("pos_ovf", 4);
    step();
    send(16'h8000, 16'hFFFF, 1'b0, 1'b1);
    collect("neg_ovf", 4);
    step();

    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 1'b1);
    collect("bp", 4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, e_last.s);
      chk("bp_cout", carry_out, e_last.co);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    send(16'hAAAA, 16'h1111, 1'b0, 1'b1);
    collect("bp_next", 4);
    step();

    send(16'd10, 16'd22, 1'b0, 1'b0);
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", carry_out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("no_stale_out", out_valid, 0);
    send(16'd5, 16'd6, 1'b0, 1'b1);
    collect("post_rst", 4);
    step();
    chk("sb_drained", sbq.size(), 0);

    a32 = 32'h8000_0000;
    b32 = 32'h8000_0000;
    v32 = 1'b1;
    step();
    v32 = 1'b0;
    w = 0;
    while (!o32 && w < 20) begin
      step();
      w++;
    end
    chk("w32_latency", w, 4);
    chk("w32_sum", s32, 0);
    chk("w32_cout", c32, 1);

    a8 = 8'd200;
    b8 = 8'd100;
    v8 = 1'b1;
    step();
    v8 = 1'b0;
    w = 0;
    while (!o8 && w < 20) begin
      step();
      w++;
    end
    chk("w8_latency", w, 1);
    chk("w8_sum", s8, 8'd44);
    chk("w8_cout", c8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
